seq_addsub: RTL



---
 rtl/seq_addsub.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB first, carry held in a register between chunks.
// Latency: start accepted at edge 0, done pulses for the cycle after edge N (N = WIDTH/CHUNK); one op per N+1 cycles.
// Backpressure: none; start is ignored while busy, and operands/mode are latched at accept.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, sub       request (sampled when not busy), 0 = a+b / 1 = a-b
//   a, b             WIDTH-bit operands
//   busy, done       high while running / one-cycle result-valid pulse
//   sum              result, held until the next completed operation
//   c_out, ovf, zero carry out of MSB (not-borrow for subtract), signed overflow, sum == 0
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_addsub: WIDTH must be at least 2");
  end
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("seq_addsub: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;       // already inverted for subtract
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  res_q;     // partial result, only exposed via sum at DONE
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  sum_q;
  logic              c_q;
  logic              v_q;
  logic              z_q;

  // Chunk datapath
  int unsigned       lsb;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  s_chunk;
  logic              c_chunk_d;
  logic              c_into_top_d;
  logic [WIDTH-1:0]  res_d;
  logic              last_d;

  always_comb begin
    lsb     = int'(cnt_q) * CHUNK;
    a_chunk = a_q[lsb +: CHUNK];
    b_chunk = b_q[lsb +: CHUNK];
    {c_chunk_d, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Recover the carry into the chunk's top bit from its sum bit; on the last
    // chunk that bit is the word MSB, which is what signed overflow needs.
    c_into_top_d = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    res_d        = res_q;
    res_d[lsb +: CHUNK] = s_chunk;
    last_d       = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;     // +1 completes the two's-complement negation
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= c_chunk_d;
          if (last_d) begin
            // All result outputs change together, so no partial value is visible.
            sum_q   <= res_d;
            c_q     <= c_chunk_d;
            v_q     <= c_into_top_d ^ c_chunk_d;
            z_q     <= (res_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_q;
  assign ovf   = v_q;
  assign zero  = z_q;

endmodule
